// File: rtl/chain_capture_pkg.sv
// Shared constants for the scan-chain capture unit: capture state encoding,
// mode values and the frame counter width.
package chain_capture_pkg;

    localparam logic [0:0] C_IDLE  = 1'b0;
    localparam logic [0:0] C_SHIFT = 1'b1;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT    = 1'b1;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/chain_capture_unit_shift.sv
// One serial scan chain: a DEPTH-bit shift register that shifts toward the MSB,
// so the first bit shifted in ends at the MSB once the frame is complete.
module chain_shift_reg #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [DEPTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[DEPTH-2:0], din};
        end
    end

endmodule

// File: rtl/chain_capture_unit.sv
// Captures CHAINS_IN serial scan chains into frames, holds one completed frame
// in a snapshot buffer and drains it one chain word per valid/ready beat.
module chain_capture_unit
    import chain_capture_pkg::*;
#(
    parameter int CHAINS_IN   = 1,
    parameter int CHAIN_DEPTH = 8,
    parameter int IDX_W       = (CHAINS_IN > 1) ? $clog2(CHAINS_IN) : 1,
    parameter int CNT_W       = $clog2(CHAIN_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHAINS_IN-1:0]   cin,
    input  logic                   shift_en,
    input  logic                   arm,
    input  logic                   mode,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CHAIN_DEPTH-1:0] out_data,
    output logic [IDX_W-1:0]       out_chain,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overflow,
    output logic [FRAME_CNT_W-1:0] frame_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAINS_IN - 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_DEPTH - 1);

    logic [0:0]                         state;
    logic                               mode_q;
    logic [CNT_W-1:0]                   bit_cnt;
    logic [CHAINS_IN*CHAIN_DEPTH-1:0]   chain_q;
    logic [CHAINS_IN*CHAIN_DEPTH-1:0]   chain_next;
    logic [CHAINS_IN*CHAIN_DEPTH-1:0]   snapshot;
    logic                               snap_full;
    logic [IDX_W-1:0]                   rd_idx;

    logic start, step, frame_done, beat_hs, last_hs, accept;

    assign start      = (state == C_IDLE) && arm && !abort;
    assign step       = (state == C_SHIFT) && shift_en && !abort;
    assign frame_done = step && (bit_cnt == LAST_BIT);
    assign beat_hs    = snap_full && out_ready;
    assign last_hs    = beat_hs && (rd_idx == LAST_IDX);
    // A frame may land on the same edge the previous snapshot's final beat leaves.
    assign accept     = frame_done && (!snap_full || last_hs);

    for (genvar i = 0; i < CHAINS_IN; i++) begin : g_chain
        chain_shift_reg #(
            .DEPTH (CHAIN_DEPTH)
        ) u_chain (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start),
            .en    (step),
            .din   (cin[i]),
            .q     (chain_q[i*CHAIN_DEPTH +: CHAIN_DEPTH])
        );
        // Post-shift value, so the completing bit is part of the snapshot.
        assign chain_next[i*CHAIN_DEPTH +: CHAIN_DEPTH] =
            {chain_q[i*CHAIN_DEPTH +: CHAIN_DEPTH-1], cin[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= C_IDLE;
            mode_q  <= MODE_ONESHOT;
            bit_cnt <= '0;
        end else if (state == C_IDLE) begin
            if (start) begin
                state   <= C_SHIFT;
                mode_q  <= mode;
                bit_cnt <= '0;
            end
        end else begin
            if (abort) begin
                state   <= C_IDLE;
                bit_cnt <= '0;
            end else if (shift_en) begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (mode_q == MODE_ONESHOT) begin
                        state <= C_IDLE;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot    <= '0;
            snap_full   <= 1'b0;
            rd_idx      <= '0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (start) begin
                overflow <= 1'b0;
            end else if (frame_done && !accept) begin
                overflow <= 1'b1;
            end

            if (accept) begin
                snapshot    <= chain_next;
                snap_full   <= 1'b1;
                rd_idx      <= '0;
                frame_count <= frame_count + 1'b1;
            end else if (beat_hs) begin
                if (rd_idx == LAST_IDX) begin
                    rd_idx    <= '0;
                    snap_full <= 1'b0;
                end else begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < CHAINS_IN; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                out_data = snapshot[i*CHAIN_DEPTH +: CHAIN_DEPTH];
            end
        end
    end

    assign out_valid = snap_full;
    assign out_chain = rd_idx;
    assign out_last  = snap_full && (rd_idx == LAST_IDX);
    assign busy      = (state == C_SHIFT);

endmodule

// File: doc/chain_capture_unit.md
Name: chain_capture_unit

Overview:
- Parametrised successor to the single-direction scan-chain shift capture.
- Shifts CHAINS_IN serial chains of CHAIN_DEPTH bits each under a shift enable, counts bits, and snapshots each complete frame into a holding buffer.
- Drains the buffer one chain word per beat over a valid/ready port.
- Supports one-shot and continuous modes, abort, overflow detection and a frame counter. Sits between the scan-chain taps and the ShadowCapture readout logic.

Parameters:
- CHAINS_IN, 1: number of serial chains; must be ≥1.
- CHAIN_DEPTH, 8: bits per chain per frame; must be ≥2.
- IDX_W, max(1,$clog2(CHAINS_IN)): derived; width of the chain index.
- CNT_W, $clog2(CHAIN_DEPTH): derived; width of the bit counter.

Ports:
- clk, in, 1: single clock; all logic on the rising edge.
- rst_n, in, 1: reset; asynchronous, active-low.
- cin, in, CHAINS_IN: serial input bit per chain.
- shift_en, in, 1: sample cin this cycle.
- arm, in, 1: start capture; honoured only in C_IDLE.
- mode, in, 1: 0 = one-shot, 1 = continuous; sampled at arm.
- abort, in, 1: cancel the frame in progress.
- out_valid, out, 1: snapshot beat available.
- out_ready, in, 1: consumer accepts beat.
- out_data, out, CHAIN_DEPTH: snapshot word of chain out_chain.
- out_chain, out, IDX_W: index of the chain being presented.
- out_last, out, 1: beat is chain CHAINS_IN-1.
- busy, out, 1: capture FSM in C_SHIFT.
- overflow, out, 1: sticky; a completed frame was dropped.
- frame_count, out, 16: accepted snapshots, wraps at 2^16.

Behaviour:
- Reset: all outputs 0, shift registers 0, snapshot 0, bit_cnt 0, rd_idx 0, both FSMs idle. Reset mid-frame or mid-drain discards everything.
- Shift rule, per chain i, on an edge with shift_en=1 in C_SHIFT: reg_i <= {reg_i[D-2:0], cin[i]}. The first bit shifted ends at the MSB. With shift_en=0, cin is ignored and state holds.
- Capture FSM, C_IDLE:
  - arm=1 (and abort=0) -> C_SHIFT.
  - Clear shift regs and bit_cnt; latch mode; clear overflow.
- Capture FSM, C_SHIFT:
  - On an edge with shift_en=1, bit_cnt increments.
  - When bit_cnt==D-1 and shift_en=1, the frame completes at that edge: bit_cnt <= 0; the post-shift values are offered to the snapshot.
  - One-shot mode -> C_IDLE. Continuous mode stays in C_SHIFT; the next shift begins the next frame with no dead cycle.
  - arm is ignored in C_SHIFT.
- abort: in C_SHIFT -> C_IDLE with bit_cnt 0 and no snapshot. abort takes priority over frame completion and arm in the same cycle. It does not affect a snapshot already held.
- Snapshot/readout:
  - snap_full is set when a frame is accepted. out_valid = snap_full, so it goes high in the cycle after the completing edge.
  - out_data = snapshot[rd_idx]; out_chain = rd_idx.
  - On out_valid & out_ready: rd_idx++. On the last beat, rd_idx <= 0 and snap_full <= 0.
  - out_data and out_chain are stable while out_valid=1 and out_ready=0.
- Acceptance:
  - A completing frame is accepted if snap_full=0, or if the final beat handshakes on the same edge. In the coincident case the new snapshot loads, snap_full stays 1 and rd_idx = 0.
  - Otherwise the frame is dropped, overflow <= 1, and snapshot and frame_count are unchanged.
  - frame_count increments only on acceptance.
- busy: 1 exactly while in C_SHIFT.

Decomposition:
- Shared package chain_capture_pkg:
  - capture state encoding C_IDLE/C_SHIFT.
  - mode constants MODE_ONESHOT=0, MODE_CONT=1.
  - FRAME_CNT_W=16.
- Sub-module chain_shift_reg: a CHAIN_DEPTH-wide shift register with synchronous clear and enable. One instance per chain in a generate loop.
- Control FSM, counters and snapshot buffer live in the top module.

Test Plan (CHAINS_IN=2, CHAIN_DEPTH=4 unless noted):
- Reset check: hold rst_n=0 with random inputs -> every output 0. Release -> still 0 and busy=0.
- One-shot capture:
  - Stimulus: arm with mode=0; 4 consecutive shifts with cin[0]=1,0,1,1 and cin[1]=0,0,1,0; out_ready=1.
  - Response: busy falls after the 4th edge. Beat 0 is out_data=4'b1011, out_chain=0. Beat 1 is 4'b0010, out_chain=1, out_last=1. frame_count=1.
- Gapped shift_en: same bits with shift_en=0 for 3 cycles between each bit and cin toggling during the gaps -> identical beats to the one-shot test.
- Backpressure overflow:
  - Stimulus: mode=1, out_ready=0, 8 shifts of two distinct frames.
  - Response: the first frame is held, overflow=1, frame_count=1. After out_ready=1, the first frame's data is drained.
- Coincident drain and completion: continuous mode, final beat handshake on the same edge as the next frame's 4th shift -> overflow=0, frame_count increments, new frame presented with out_chain=0.
- Abort and re-arm:
  - Stimulus: abort after 2 shifts.
  - Response: busy=0 and no out_valid. Re-arm plus 4 shifts of 0,1,1,0 gives exactly 4'b0110, so no stale bits remain. rst_n pulse mid-drain drops out_valid to 0 immediately.
